// File: rtl/microprog_loader_fifo.sv
// Packs loader command words into microprogram entries and queues them for the sequencer.
// Read data is registered one cycle after a pop; the loader is stalled via wr_ready while a completed entry waits for FIFO space.
module microprog_loader_fifo #(
  parameter int MICROPROG_LEN_WORDS = 4,
  parameter int CMD_SIZE_BITS       = 64,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_valid,
  input  logic [CMD_SIZE_BITS-1:0]                      wr_data,
  input  logic                                          wr_last,
  output logic                                          wr_ready,
  input  logic                                          fifo_read_en,
  output logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0]  fifo_read_data,
  output logic                                          fifo_empty,
  output logic                                          fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]               fifo_count,
  output logic                                          underflow_err
);
  localparam int TOT  = CMD_SIZE_BITS * MICROPROG_LEN_WORDS;
  localparam int IDXW = (MICROPROG_LEN_WORDS > 1) ? $clog2(MICROPROG_LEN_WORDS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH+1);

  typedef enum logic {S_FILL = 1'b0, S_PEND = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [TOT-1:0]    r_pack;
  logic [TOT-1:0]    r_stage;
  logic [TOT-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [TOT-1:0]    r_rdata;
  logic              r_uflow;

  logic              w_accept, w_complete, w_pop, w_room, w_push, w_stage_ld;
  logic [TOT-1:0]    w_entry, w_push_dat;

  // Words above the current index are always zero in r_pack, so completion zero-fills for free.
  always_comb begin
    w_entry = r_pack;
    for (int k = 0; k < MICROPROG_LEN_WORDS; k++) begin
      if (r_idx == IDXW'(k)) w_entry[k*CMD_SIZE_BITS +: CMD_SIZE_BITS] = wr_data;
    end
  end

  assign w_accept   = wr_valid && wr_ready;
  assign w_complete = w_accept && ((r_idx == IDXW'(MICROPROG_LEN_WORDS-1)) || wr_last);
  assign w_pop      = fifo_read_en && (r_count != '0);
  assign w_room     = (r_count < CW'(FIFO_DEPTH)) || w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    w_push      = 1'b0;
    w_push_dat  = r_stage;
    w_stage_ld  = 1'b0;
    case (r_state)
      S_FILL: begin
        wr_ready   = 1'b1;
        w_push_dat = w_entry;
        if (w_complete) begin
          if (w_room) begin
            w_push = 1'b1;
          end else begin
            w_stage_ld  = 1'b1;
            w_state_nxt = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (w_room) begin
          w_push      = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_pack  <= '0;
      r_stage <= '0;
    end else begin
      if (w_complete) begin
        r_idx  <= '0;
        r_pack <= '0;
      end else if (w_accept) begin
        r_idx  <= r_idx + IDXW'(1);
        r_pack <= w_entry;
      end
      if (w_stage_ld) r_stage <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_dat;
  end

  // Push and pop on a full FIFO hit the same slot; the pop still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
      r_uflow <= 1'b0;
    end else begin
      r_uflow <= fifo_read_en && (r_count == '0);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr  <= r_rptr + PW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_read_data = r_rdata;
  assign fifo_count     = r_count;
  assign fifo_empty     = (r_count == '0);
  assign fifo_full      = (r_count == CW'(FIFO_DEPTH));
  assign underflow_err  = r_uflow;

endmodule

// File: tb/tb_microprog_loader_fifo.sv
// Directed and random stimulus against a queue-based model of the microprogram FIFO.
module tb_microprog_loader_fifo;
  localparam int L = 4;
  localparam int W = 64;
  localparam int D = 4;
  localparam int T = L * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic          fifo_read_en = 1'b0;
  logic [T-1:0]  fifo_read_data;
  logic          fifo_empty, fifo_full, underflow_err;
  logic [2:0]    fifo_count;

  int total = 0;
  int bad   = 0;

  logic [T-1:0] m_q[$];
  logic [T-1:0] m_part, m_stage, m_rdata;
  int           m_pidx;
  bit           m_pend, m_uf;

  microprog_loader_fifo #(.MICROPROG_LEN_WORDS(L), .CMD_SIZE_BITS(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [T-1:0] obs, input logic [T-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("read_data", fifo_read_data, m_rdata);
    chk("count", T'(fifo_count), T'(m_q.size()));
    chk("empty", T'(fifo_empty), T'(m_q.size() == 0));
    chk("full", T'(fifo_full), T'(m_q.size() == D));
    chk("underflow", T'(underflow_err), T'(m_uf));
  endtask

  // One clock: drive inputs, predict the edge from the model, then compare after the edge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit last, input bit rd);
    bit pop, room;
    wr_valid = v; wr_data = d; wr_last = last; fifo_read_en = rd;
    #1;
    chk("wr_ready", T'(wr_ready), T'(!m_pend));
    pop  = rd && (m_q.size() != 0);
    room = (m_q.size() < D) || pop;
    m_uf = rd && (m_q.size() == 0);
    if (pop) m_rdata = m_q.pop_front();
    if (!m_pend && v) begin
      m_part[m_pidx*W +: W] = d;
      if (m_pidx == L-1 || last) begin
        if (room) m_q.push_back(m_part);
        else begin m_pend = 1; m_stage = m_part; end
        m_part = '0; m_pidx = 0;
      end else m_pidx++;
    end else if (m_pend && room) begin
      m_q.push_back(m_stage);
      m_pend = 0;
    end
    @(posedge clk); #1;
    wr_valid = 0; wr_last = 0; fifo_read_en = 0;
    chk_outputs();
  endtask

  task automatic do_reset();
    wr_valid = 0; wr_last = 0; fifo_read_en = 0;
    rst = 1; #2;
    m_q.delete(); m_part = '0; m_stage = '0; m_rdata = '0; m_pidx = 0; m_pend = 0; m_uf = 0;
    chk_outputs();
    chk("wr_ready_rst", T'(wr_ready), T'(1));
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic write_entry(input int tag);
    for (int k = 0; k < L; k++) cyc(1, W'(tag * 16 + k), 0, 0);
  endtask

  initial begin
    do_reset();

    // Entry packing
    cyc(1, 64'h11, 0, 0); cyc(1, 64'h22, 0, 0); cyc(1, 64'h33, 0, 0); cyc(1, 64'h44, 0, 0);
    chk("pack_count", T'(fifo_count), T'(1));
    cyc(0, 0, 0, 1);
    chk("pack_data", fifo_read_data, {64'h44, 64'h33, 64'h22, 64'h11});

    // Short program
    cyc(1, 64'hA1, 0, 0); cyc(1, 64'hA2, 1, 0); cyc(0, 0, 0, 1);
    chk("short_data", fifo_read_data, {64'h0, 64'h0, 64'hA2, 64'hA1});
    cyc(1, 64'hC0, 0, 0); cyc(1, 64'hC1, 0, 0); cyc(1, 64'hC2, 0, 0); cyc(1, 64'hC3, 1, 0);
    cyc(0, 0, 0, 1);
    chk("restart_data", fifo_read_data, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

    // Full with staging
    for (int e = 1; e <= 5; e++) write_entry(e);
    chk("full_flag", T'(fifo_full), T'(1));
    chk("pend_ready", T'(wr_ready), T'(0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("stage_count", T'(fifo_count), T'(4));
    chk("stage_head", fifo_read_data, {64'h13, 64'h12, 64'h11, 64'h10});
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("stage_last", fifo_read_data, {64'h53, 64'h52, 64'h51, 64'h50});

    // Underflow while empty
    cyc(0, 0, 0, 1);
    chk("uf_pulse", T'(underflow_err), T'(1));
    cyc(0, 0, 0, 0);

    // Pop in the same cycle as the first push into an empty FIFO
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 1);
    cyc(0, 0, 0, 1);

    // Wrap with at most two outstanding
    for (int e = 1; e <= 10; e++) begin
      write_entry(e);
      chk("wrap_max", T'(fifo_count <= 2), T'(1));
      if (m_q.size() == 2) cyc(0, 0, 0, 1);
    end
    while (m_q.size() != 0) cyc(0, 0, 0, 1);

    // Reset mid-entry
    cyc(1, 64'hEE, 0, 0); cyc(1, 64'hEF, 0, 0);
    do_reset();
    cyc(1, 64'hB0, 0, 0); cyc(1, 64'hB1, 0, 0); cyc(1, 64'hB2, 0, 0); cyc(1, 64'hB3, 0, 0);
    chk("rst_count", T'(fifo_count), T'(1));
    cyc(0, 0, 0, 1);
    chk("rst_data", fifo_read_data, {64'hB3, 64'hB2, 64'hB1, 64'hB0});

    // Reset during S_PEND drops the staged entry
    for (int e = 1; e <= 5; e++) write_entry(e);
    do_reset();

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) == 0);
    while (m_q.size() != 0 || m_pend) cyc(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
